// File: rtl/stage_2.sv
// Range-update stage of the arithmetic encoder: multiplicative range update,
// bool symbols, renormalization, and per-symbol low increment / shift output.
module stage_2 #(
  parameter int RANGE_WIDTH    = 16,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_DATA_WIDTH = 16,
  parameter int D_WIDTH        = 4
) (
  input  logic                      clk_stage_2,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [RANGE_WIDTH-1:0]    UU,
  input  logic [RANGE_WIDTH-1:0]    VV,
  input  logic                      COMP_mux_1,
  input  logic                      bool_n,
  input  logic [SYMBOL_WIDTH-1:0]   symbol,
  input  logic [LUT_DATA_WIDTH-1:0] lut_u,
  input  logic [LUT_DATA_WIDTH-1:0] lut_v,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RANGE_WIDTH-1:0]    low_add,
  output logic [D_WIDTH-1:0]        shift_d,
  output logic [RANGE_WIDTH-1:0]    range_out,
  output logic [15:0]               sym_count,
  output logic                      err
);

  localparam int PW = RANGE_WIDTH + 8;
  typedef logic [RANGE_WIDTH-1:0] rng_t;
  typedef logic [RANGE_WIDTH:0]   ext_t;
  typedef logic [PW-1:0]          prod_t;

  localparam rng_t RNG_INIT = {1'b1, {(RANGE_WIDTH-1){1'b0}}};
  localparam ext_t BOOL_INC = {{(RANGE_WIDTH-2){1'b0}}, 3'd4};

  // Shift needed to bring the top set bit of x up to the MSB position.
  function automatic logic [D_WIDTH-1:0] lead_zeros(input rng_t x);
    logic [D_WIDTH-1:0] n;
    n = {D_WIDTH{1'b0}};
    for (int i = 0; i < RANGE_WIDTH; i++) begin
      if (x[i]) begin
        n = D_WIDTH'(RANGE_WIDTH - 1 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  rng_t               rng_r;
  rng_t               low_add_r;
  rng_t               range_out_r;
  logic [D_WIDTH-1:0] shift_d_r;
  logic [15:0]        sym_count_r;
  logic               out_valid_r;
  logic               err_r;

  logic [7:0]         r8_s;
  ext_t               pu_s, pv_s, u_s, vn_s, vb_s;
  rng_t               rng_p_s, low_add_s, rng_next_s;
  logic [D_WIDTH-1:0] d_s;
  logic               zero_s, accept_s, unused_s;

  assign in_ready = ~flush & (~out_valid_r | out_ready);
  assign accept_s = in_valid & in_ready;

  assign r8_s = rng_r[RANGE_WIDTH-1 -: 8];
  assign pu_s = ext_t'((prod_t'(r8_s) * prod_t'(UU)) >> 1);
  assign pv_s = ext_t'((prod_t'(r8_s) * prod_t'(VV)) >> 1);
  assign u_s  = pu_s + ext_t'(lut_u);
  assign vn_s = pv_s + ext_t'(lut_v);
  assign vb_s = pv_s + BOOL_INC;
  assign unused_s = ^symbol[SYMBOL_WIDTH-1:1];

  // Select the unnormalized new range and the low increment for this symbol.
  always_comb begin
    low_add_s = {RANGE_WIDTH{1'b0}};
    rng_p_s   = {RANGE_WIDTH{1'b0}};
    if (!bool_n) begin
      if (symbol[0]) begin
        low_add_s = rng_t'(ext_t'(rng_r) - vb_s);
        rng_p_s   = rng_t'(vb_s);
      end else begin
        low_add_s = {RANGE_WIDTH{1'b0}};
        rng_p_s   = rng_t'(ext_t'(rng_r) - vb_s);
      end
    end else if (COMP_mux_1) begin
      low_add_s = rng_t'(ext_t'(rng_r) - u_s);
      rng_p_s   = rng_t'(u_s - vn_s);
    end else begin
      low_add_s = {RANGE_WIDTH{1'b0}};
      rng_p_s   = rng_t'(ext_t'(rng_r) - vn_s);
    end
  end

  // A zero range cannot be normalized; fall back to the reset range.
  assign zero_s     = (rng_p_s == {RANGE_WIDTH{1'b0}});
  assign d_s        = zero_s ? {D_WIDTH{1'b0}} : lead_zeros(rng_p_s);
  assign rng_next_s = zero_s ? RNG_INIT : (rng_p_s << d_s);

  // Range feedback, output registers, symbol counter and sticky error.
  always_ff @(posedge clk_stage_2) begin
    if (reset) begin
      rng_r       <= RNG_INIT;
      low_add_r   <= {RANGE_WIDTH{1'b0}};
      range_out_r <= RNG_INIT;
      shift_d_r   <= {D_WIDTH{1'b0}};
      sym_count_r <= 16'd0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (flush) begin
        rng_r       <= RNG_INIT;
        sym_count_r <= 16'd0;
      end else if (accept_s) begin
        rng_r       <= rng_next_s;
        low_add_r   <= low_add_s;
        range_out_r <= rng_next_s;
        shift_d_r   <= d_s;
        sym_count_r <= sym_count_r + 16'd1;
        err_r       <= err_r | zero_s;
      end else begin
        rng_r <= rng_r;
      end
      if (accept_s) begin
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign low_add   = low_add_r;
  assign shift_d   = shift_d_r;
  assign range_out = range_out_r;
  assign sym_count = sym_count_r;
  assign err       = err_r;

endmodule

// File: tb/tb_stage_2.sv
// Self-checking bench for stage_2: per-cycle reference model plus directed
// vectors with hand-computed expectations.
module tb_stage_2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, COMP_mux_1, bool_n;
  logic [15:0] UU, VV, lut_u, lut_v;
  logic [3:0]  symbol;
  logic        in_ready, out_valid, err;
  logic [15:0] low_add, range_out, sym_count;
  logic [3:0]  shift_d;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stage_2 dut (
    .clk_stage_2(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .UU(UU), .VV(VV), .COMP_mux_1(COMP_mux_1), .bool_n(bool_n),
    .symbol(symbol), .lut_u(lut_u), .lut_v(lut_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .low_add(low_add), .shift_d(shift_d), .range_out(range_out),
    .sym_count(sym_count), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the range-update rules.
  function automatic void ref_sym(input int rng, input int uu, input int vv,
                                  input bit comp, input bit booln, input bit sym,
                                  input int lu, input int lv,
                                  output int low, output int rn, output int d,
                                  output bit zero);
    int r8, pu, pv, u, v, rp;
    r8 = rng / 256;
    pu = (r8 * uu) / 2;
    pv = (r8 * vv) / 2;
    if (booln) begin
      if (comp) begin
        u = pu + lu; v = pv + lv;
        low = rng - u; rp = u - v;
      end else begin
        v = pv + lv;
        low = 0; rp = rng - v;
      end
    end else begin
      v = pv + 4;
      if (sym) begin low = rng - v; rp = v; end
      else     begin low = 0;       rp = rng - v; end
    end
    low = low & 32'hFFFF;
    rp  = rp & 32'hFFFF;
    zero = (rp == 0);
    d = 0;
    if (zero) begin
      rn = 32768;
    end else begin
      rn = rp;
      while (rn < 32768) begin rn = rn * 2; d++; end
    end
  endfunction

  int m_rng, m_low, m_d, m_range, m_cnt;
  bit m_valid, m_err;

  // Reference model state, advanced on the same edge as the DUT.
  always @(posedge clk) begin : model
    int lo, rn, d;
    bit z;
    if (reset) begin
      m_rng <= 32768; m_low <= 0; m_d <= 0; m_range <= 32768;
      m_cnt <= 0; m_valid <= 1'b0; m_err <= 1'b0;
    end else begin
      if (flush) begin
        m_rng <= 32768; m_cnt <= 0;
      end
      if (in_valid && !flush && (!m_valid || out_ready)) begin
        ref_sym(m_rng, UU, VV, COMP_mux_1, bool_n, symbol[0], lut_u, lut_v, lo, rn, d, z);
        m_rng <= rn; m_low <= lo; m_d <= d; m_range <= rn;
        m_cnt <= (m_cnt + 1) % 65536; m_valid <= 1'b1;
        if (z) m_err <= 1'b1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, !flush && (!m_valid || out_ready));
      check("sym_count", sym_count, m_cnt);
      check("err", err, m_err);
      if (m_valid) begin
        check("low_add", low_add, m_low);
        check("shift_d", shift_d, m_d);
        check("range_out", range_out, m_range);
      end
    end
  end

  task automatic set_vec(input bit comp, input bit bn, input bit sym,
                         input int uu, input int vv, input int lu, input int lv);
    COMP_mux_1 = comp; bool_n = bn; symbol = {3'd0, sym};
    UU = 16'(uu); VV = 16'(vv); lut_u = 16'(lu); lut_v = 16'(lv);
  endtask

  task automatic send(input bit comp, input bit bn, input bit sym,
                      input int uu, input int vv, input int lu, input int lv);
    set_vec(comp, bn, sym, uu, vv, lu, lv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int lo, input int d, input int rn, input int cnt);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_low_add"}, low_add, lo);
    check({tag, "_shift_d"}, shift_d, d);
    check({tag, "_range"}, range_out, rn);
    check({tag, "_count"}, sym_count, cnt);
  endtask

  typedef struct { bit c; bit b; bit s; int uu; int vv; int lu; int lv; } vec_t;
  vec_t tbl[8];

  initial begin
    bit acc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_vec(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_range", range_out, 16'h8000);
    check("rst_low_add", low_add, 0);
    check("rst_shift", shift_d, 0);
    check("rst_count", sym_count, 0);
    check("rst_err", err, 0);

    send(1'b1, 1'b1, 1'b0, 384, 128, 12, 8);
    expect_out("nonbool", 8180, 1, 16'h8008, 1);
    do_reset();
    check("reset_clears_valid", out_valid, 0);
    send(1'b0, 1'b1, 1'b0, 0, 384, 0, 12);
    expect_out("first", 0, 3, 16'hFFA0, 1);
    do_reset();
    send(1'b0, 1'b0, 1'b1, 0, 256, 0, 0);
    expect_out("bool1", 16380, 1, 16'h8008, 1);
    do_reset();
    send(1'b0, 1'b0, 1'b0, 0, 256, 0, 0);
    expect_out("bool0", 0, 2, 16'hFFF0, 1);

    // Backpressure: A accepted, B waits three stalled cycles, then chains from A.
    do_reset();
    out_ready = 1'b0;
    set_vec(1'b1, 1'b1, 1'b0, 384, 128, 12, 8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_vec(1'b0, 1'b0, 1'b1, 0, 256, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", in_ready, 0);
      expect_out("bp_hold", 8180, 1, 16'h8008, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("bp_chain", 16388, 1, 16'h8008, 2);
    @(posedge clk); #1;

    // Directed table, back to back with intermittent downstream stalls.
    tbl[0] = '{1, 1, 0, 300, 100, 20, 4};
    tbl[1] = '{0, 1, 0, 0, 500, 0, 16};
    tbl[2] = '{1, 1, 0, 1000, 10, 40, 4};
    tbl[3] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 1000, 0, 0};
    tbl[5] = '{1, 1, 0, 255, 254, 4, 0};
    tbl[6] = '{1, 1, 0, 640, 64, 8, 4};
    tbl[7] = '{0, 0, 1, 0, 200, 0, 0};
    for (int i = 0; i < 8; i++) begin
      set_vec(tbl[i].c, tbl[i].b, tbl[i].s, tbl[i].uu, tbl[i].vv, tbl[i].lu, tbl[i].lv);
      in_valid = 1'b1;
      out_ready = (i % 3 != 2);
      acc = 1'b0;
      for (int k = 0; k < 6 && !acc; k++) begin
        acc = in_ready;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      if (!acc) check("table_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Flush alongside a valid input: nothing accepted, range and count restart.
    set_vec(1'b1, 1'b1, 1'b0, 384, 128, 12, 8);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_count", sym_count, 0);
    check("flush_no_accept", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("after_flush", 8180, 1, 16'h8008, 1);

    // Flush with a stalled result: the result stays valid.
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_keep_valid", out_valid, 1);
    check("flush_keep_range", range_out, 16'h8008);
    check("flush_keep_count", sym_count, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);

    // Zero range sets sticky err; flush does not clear it, reset does.
    send(1'b1, 1'b1, 1'b0, 200, 200, 0, 0);
    expect_out("zero", 19968, 0, 16'h8000, 1);
    check("zero_err", err, 1);
    send(1'b1, 1'b1, 1'b0, 384, 128, 12, 8);
    expect_out("post_zero", 8180, 1, 16'h8008, 2);
    check("err_sticky", err, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("err_after_flush", err, 1);

    // Reset mid-stream wins over flush and accept.
    out_ready = 1'b0;
    send(1'b0, 1'b1, 1'b0, 0, 384, 0, 12);
    check("pend_valid", out_valid, 1);
    set_vec(1'b1, 1'b1, 1'b0, 384, 128, 12, 8);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_err", err, 0);
    check("mid_reset_count", sym_count, 0);
    check("mid_reset_range", range_out, 16'h8000);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_2.md
# stage_2

Range-update stage of the arithmetic encoder pipeline. It sits directly downstream of `stage_1` and consumes its outputs: `UU`, `VV`, `COMP_mux_1`, `bool_out`, `out_symbol`, `lut_u_out` and `lut_v_out`. It holds the encoder range register and applies the multiplicative range update, including bool symbols. It then renormalizes the range and emits, per symbol, the low-increment and shift count consumed by the low/carry stage.

## Interface
Parameters:
- RANGE_WIDTH, 16, width of range, UU/VV, low_add
- SYMBOL_WIDTH, 4, symbol width
- LUT_DATA_WIDTH, 16, width of the min-probability offsets from the LUTs
- D_WIDTH, 4, width of the renormalization shift

Ports:
- clk_stage_2  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- flush  in  1  one-cycle pulse: reload range to 0x8000 and clear the counter
- in_valid  in  1  stage_1 data valid
- in_ready  out  1  stage accepts data this cycle
- UU, VV  in  RANGE_WIDTH  FL>>6, FH>>6
- COMP_mux_1  in  1  1 = FL < 32768 (not the first symbol)
- bool_n  in  1  active-low bool flag (stage_1 `bool_out`)
- symbol  in  SYMBOL_WIDTH  symbol; bit 0 = value for bool
- lut_u, lut_v  in  LUT_DATA_WIDTH  4·(N−(s−1)), 4·(N−s)
- out_valid  out  1  output registers hold a result
- out_ready  in  1  downstream accepts
- low_add  out  RANGE_WIDTH  value to add to low
- shift_d  out  D_WIDTH  renormalization shift, 0..15
- range_out  out  RANGE_WIDTH  normalized range after this symbol
- sym_count  out  16  symbols processed since reset/flush; wraps
- err  out  1  sticky: a zero range was produced

## Operation
- Accept when `in_valid & in_ready & ~flush`. Define `in_ready = ~out_valid | out_ready`.
- Let `r8 = rng[15:8]`, `pu = (r8*UU)>>1`, `pv = (r8*VV)>>1`. Intermediates are 17 bits wide, and results are truncated to 16 bits.
- Non-bool (`bool_n=1`):
  - With `COMP_mux_1=1`: `u = pu+lut_u`, `v = pv+lut_v`, `low_add = rng−u`, `rng' = u−v`.
  - With `COMP_mux_1=0`: `v = pv+lut_v`, `low_add = 0`, `rng' = rng−v`. `lut_u` is ignored.
- Bool (`bool_n=0`): `v = pv+4`. `lut_u`, `lut_v` and `COMP_mux_1` are ignored.
  - If `symbol[0]=1`: `low_add = rng−v`, `rng' = v`.
  - If `symbol[0]=0`: `low_add = 0`, `rng' = rng−v`.
- Renormalization: `d = 15 − msb_index(rng')` and `rng_next = rng' << d`, so the result is in [0x8000, 0xFFFF]. This is computed combinationally in the same cycle.
- `rng' == 0` (illegal input): set `err`, `d = 0`, `rng_next = 0x8000`. The output is still produced, with `low_add` as computed.
- On accept, `rng`, `low_add`, `shift_d`, `range_out` and `sym_count+1` are registered together, and `out_valid` is set.
- When `out_valid & ~out_ready`, all output registers hold and no new input is accepted.

## Timing
- Reset values: `rng = 0x8000`, `out_valid = 0`, `low_add = 0`, `shift_d = 0`, `range_out = 0x8000`, `sym_count = 0`, `err = 0`. `in_ready = 1` after reset.
- Latency is 1 cycle from the accept edge to `out_valid`. Throughput is 1 symbol/cycle with back-to-back accepts, because the range feedback closes in one cycle.
- `flush` has priority over `in_valid`: no accept that cycle and `in_ready` is forced low. The next edge sets `rng = 0x8000` and `sym_count = 0`. A pending `out_valid` result is kept and not dropped. `err` is not cleared; only reset clears it.
- Reset asserted mid-stream discards the pending output. Reset wins over flush and over accept.
- `sym_count` wraps 0xFFFF → 0.

## Test plan
- After reset, non-bool: UU=384, VV=128, COMP_mux_1=1, lut_u=12, lut_v=8 → next cycle low_add=8180, shift_d=1, range_out=0x8008, sym_count=1.
- After reset, first symbol: COMP_mux_1=0, VV=384, lut_v=12 → low_add=0, shift_d=3, range_out=0xFFA0.
- After reset, bool: bool_n=0, VV=256.
  - symbol=1 → low_add=16380, shift_d=1, range_out=0x8008.
  - Repeat after reset with symbol=0 → low_add=0, shift_d=2, range_out=0xFFF0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, no symbol lost. Release → results arrive in order with the correct chained range.
- Flush with in_valid=1 in the same cycle → input not accepted; next cycle range=0x8000 and sym_count=0. Re-presenting the symbol reproduces the first test's result.
- Zero range: non-bool, COMP_mux_1=1, UU=VV, lut_u=lut_v=0 → err=1 (sticky), shift_d=0, range_out=0x8000.
